// File: rtl/router_rx_pkg.sv
// ============================================================================
// Module   : router_rx_pkg
// Brief    : Shared types for the router receive port (FSM states, FIFO word).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package router_rx_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        IDLE   = 2'd1,
        RECV   = 2'd2,
        EOP    = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              sop;
        logic              eop;
        logic              err;
    } rx_entry_t;

endpackage

`default_nettype wire

// File: rtl/router_rx_fifo.sv
// ============================================================================
// Module   : router_rx_fifo
// Brief    : First-word-fall-through FIFO of rx_entry_t with wrap-bit pointers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_rx_fifo
    import router_rx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  rx_entry_t wdata,
    input  logic      pop,
    output rx_entry_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int c_ADDR_W = $clog2(DEPTH);

    rx_entry_t             r_mem [DEPTH];
    logic [c_ADDR_W:0]     r_wr_ptr;
    logic [c_ADDR_W:0]     r_rd_ptr;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                   (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);

    // A same-cycle pop frees the head slot, so a push while full still lands.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= wdata;
    end

    assign rdata = empty ? '0 : r_mem[r_rd_ptr[c_ADDR_W-1:0]];

endmodule

`default_nettype wire

// File: rtl/router_rx_port.sv
// ============================================================================
// Module   : router_rx_port
// Brief    : Serial router output deserialiser with tagged FWFT byte queue.
//            Optional statistics counters enabled by ROUTER_RX_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_rx_port
    import router_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              dout,
    input  logic              valido_n,
    input  logic              frameo_n,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_sop,
    output logic              byte_eop,
    output logic              byte_err,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              runt,
    input  logic              ovf_clr,
`ifdef ROUTER_RX_STATS_EN
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  err_cnt,
`endif
    output logic              overflow
);

    rx_state_e         r_state, w_state_nx;
    logic [BYTE_W-1:0] r_shift, w_shift_nx;
    logic [3:0]        r_bitcnt, w_cnt_nx;
    rx_entry_t         r_hold, w_hold_nx;
    logic              r_hold_vld, w_hold_vld_nx;
    logic              r_sop_done, w_sop_done_nx;
    logic              r_runt, w_runt;
    logic              r_overflow;
    logic              w_push;
    rx_entry_t         w_push_data;
    rx_entry_t         w_head;
    logic              w_full, w_empty, w_pop, w_drop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= RESYNC;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx    = r_state;
        w_shift_nx    = r_shift;
        w_cnt_nx      = r_bitcnt;
        w_hold_nx     = r_hold;
        w_hold_vld_nx = r_hold_vld;
        w_sop_done_nx = r_sop_done;
        w_push        = 1'b0;
        w_push_data   = r_hold;
        w_runt        = 1'b0;
        case (r_state)
            RESYNC: begin
                if (frameo_n) w_state_nx = IDLE;
            end
            IDLE: begin
                if (!frameo_n) begin
                    w_state_nx = RECV;
                    if (!valido_n) begin
                        w_shift_nx[0] = dout;
                        w_cnt_nx      = 4'd1;
                    end
                end
            end
            RECV: begin
                if (!valido_n) begin
                    w_shift_nx[r_bitcnt[2:0]] = dout;
                    w_cnt_nx                  = r_bitcnt + 4'd1;
                end
                // Full byte or trailing partial byte: older held byte goes out first.
                if (w_cnt_nx == 4'd8 || (frameo_n && w_cnt_nx != 4'd0)) begin
                    w_push        = r_hold_vld;
                    w_hold_nx     = '{data: w_shift_nx, sop: ~r_sop_done, eop: 1'b0,
                                      err: (w_cnt_nx != 4'd8)};
                    w_hold_vld_nx = 1'b1;
                    w_sop_done_nx = 1'b1;
                    w_cnt_nx      = 4'd0;
                    w_shift_nx    = '0;
                end
                if (frameo_n) w_state_nx = EOP;
            end
            EOP: begin
                w_push          = r_hold_vld;
                w_push_data.eop = 1'b1;
                w_runt          = ~r_hold_vld;
                w_hold_vld_nx   = 1'b0;
                w_sop_done_nx   = 1'b0;
                w_cnt_nx        = 4'd0;
                w_shift_nx      = '0;
                w_state_nx      = frameo_n ? IDLE : RECV;
            end
            default: w_state_nx = RESYNC;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_sop_done <= 1'b0;
            r_runt     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_shift    <= w_shift_nx;
            r_bitcnt   <= w_cnt_nx;
            r_hold     <= w_hold_nx;
            r_hold_vld <= w_hold_vld_nx;
            r_sop_done <= w_sop_done_nx;
            r_runt     <= w_runt;
            r_overflow <= ovf_clr ? 1'b0 : (r_overflow | w_drop);
        end
    end

    router_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clock),
        .rst_n (reset_n),
        .push  (w_push),
        .wdata (w_push_data),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_pop  = ~w_empty & byte_ready;
    assign w_drop = w_push & w_full & ~w_pop;

    assign byte_valid = ~w_empty;
    assign byte_data  = w_head.data;
    assign byte_sop   = w_head.sop;
    assign byte_eop   = w_head.eop;
    assign byte_err   = w_head.err;
    assign runt       = r_runt;
    assign overflow   = r_overflow;

`ifdef ROUTER_RX_STATS_EN
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [CNT_W-1:0] r_pkt_cnt, r_err_cnt;
    logic [1:0]       w_err_inc;
    logic [CNT_W:0]   w_err_sum;

    assign w_err_inc = 2'(w_push & w_push_data.err) + 2'(w_runt) + 2'(w_drop);
    assign w_err_sum = {1'b0, r_err_cnt} + (CNT_W+1)'(w_err_inc);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_push && w_push_data.eop && r_pkt_cnt != c_CNT_MAX)
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            r_err_cnt <= w_err_sum[CNT_W] ? c_CNT_MAX : w_err_sum[CNT_W-1:0];
        end
    end

    assign pkt_cnt = r_pkt_cnt;
    assign err_cnt = r_err_cnt;
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = |CNT_W;
`endif

endmodule

`default_nettype wire

// File: doc/router_rx_port.md
Name: router_rx_port

Overview:
- Receive-side endpoint for one router output port.
- Samples the serial dout/valido_n/frameo_n stream and deserialises bits (LSB first) into bytes.
- Tags each byte with start-of-packet, end-of-packet and error flags, and queues it in a first-word-fall-through FIFO.
- Downstream logic pops bytes with a valid/ready handshake. One instance per router output port.

Parameters:
FIFO_DEPTH, 8, FIFO entries; power of two, at least 2.
CNT_W, 16, width of the statistics counters (used only with ROUTER_RX_STATS_EN).

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
dout  in  1  serial data bit from the router.
valido_n  in  1  active low; dout is valid this cycle.
frameo_n  in  1  active low while a frame is in progress; high in the cycle that carries the last bit.
byte_data  out  8  FIFO head data.
byte_sop  out  1  head byte is the first byte of its packet.
byte_eop  out  1  head byte is the last byte of its packet.
byte_err  out  1  head byte is a zero-padded partial byte.
byte_valid  out  1  FIFO is not empty.
byte_ready  in  1  pop the head when byte_valid=1.
runt  out  1  one-cycle pulse: a frame ended with no valid bits.
overflow  out  1  sticky; a byte was dropped because the FIFO was full.
ovf_clr  in  1  synchronous clear of overflow; takes priority over a same-cycle set.

Behaviour:
- Reset: state=RESYNC; FIFO empty; hold register empty; bit counter=0; all outputs 0 (byte_data=0).
- All inputs are sampled on the rising edge of clock.
- RESYNC: ignore the line until frameo_n=1, then go to IDLE. This prevents decoding a frame that was already in progress at reset release.
- IDLE: go to RECV when frameo_n=0.
  - If valido_n=0 in that same cycle, the bit is captured.
- RECV: for each cycle with valido_n=0:
  - shift[bitcnt] <= dout, then bitcnt increments.
  - When bitcnt reaches 8, the byte completes:
    - If the hold register already holds a byte, push it to the FIFO with eop=0.
    - Load the new byte into hold; bitcnt=0.
  - sop is set on the first byte placed in hold for the packet.
  - Cycles with valido_n=1 and frameo_n=0 are padding and are ignored.
- Frame end is the RECV cycle with frameo_n=1.
  - Include that cycle's bit if valido_n=0.
  - If bits remain (0<bitcnt<8): push hold if occupied, then load the partial byte into hold, zero-padded in the high bits, with err=1.
  - Go to EOP.
- EOP, one cycle:
  - If hold is occupied, push it with eop=1.
  - If hold is empty, pulse runt for one cycle.
  - Clear hold, bitcnt and the sop flag.
  - Next state is RECV if frameo_n=0, else IDLE.
- Latency:
  - Last bit sampled at edge N → eop byte written at edge N+1 → visible on byte_valid after edge N+1.
  - Earlier bytes appear one byte-time later than completion, because of the hold register.
- FIFO is first-word-fall-through. A pop happens when byte_valid & byte_ready.
- A push while full is dropped and sets overflow, unless a pop occurs in the same cycle; in that case the push succeeds.
- The pointers use an extra wrap bit: full = MSBs differ and lower bits equal.
- Asserting reset mid-frame discards all state, including FIFO contents.
- A frame end that completes exactly 8 bits produces no err; byte_err=0 for full bytes.

Optional Feature:
ROUTER_RX_STATS_EN:
- When defined, add output ports pkt_cnt[CNT_W-1:0] and err_cnt[CNT_W-1:0].
  - pkt_cnt increments on each eop push.
  - err_cnt increments on each err=1 push, each runt, and each dropped byte.
  - Both counters saturate at all-ones and reset to 0.
- When undefined, these ports and the counter logic do not exist.

Decomposition:
- Package router_rx_pkg holds:
  - BYTE_W=8;
  - the enum rx_state_e {RESYNC, IDLE, RECV, EOP};
  - the packed struct rx_entry_t {data[7:0], sop, eop, err} used as the FIFO word.
- Sub-module router_rx_fifo: parameterised synchronous FWFT FIFO of rx_entry_t, exposing push/pop/full/empty. It is instantiated once.

Test Plan:
1. Packet 0xA5, 0x3C sent LSB first with valido_n low continuously, frameo_n high on bit 16 → output A5 (sop=1, eop=0), then 3C (sop=0, eop=1, err=0).
2. Same packet with 5 padding cycles (valido_n=1) after every 3 bits → identical byte output.
3. 12-bit packet 0xB7 + 0x9 → B7 (sop=1), then 09 (eop=1, err=1).
4. frameo_n low for 4 cycles, valido_n never low → no FIFO push; runt pulses once, one cycle after frameo_n rises.
5. FIFO_DEPTH=4, byte_ready=0, 6-byte packet → 4 entries stored, overflow=1; ovf_clr pulse → overflow=0; draining yields the first 4 bytes.
6. reset_n asserted mid-frame and released while frameo_n=0 → nothing output for that frame; the next full frame is received correctly.
